// File: rtl/leaf_egress_buffer.sv
// leaf_egress_buffer
//   Egress stage between a leaf's stream flow-control block and its
//   butterfly-fat-tree switch port. Valid packets on stream_in are captured
//   into a small first-word-fall-through FIFO and held on pkt_out until the
//   switch accepts them. A valid packet that finds the FIFO full is dropped,
//   and resend is raised on the following cycle so the flow-control block
//   re-issues it.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   stream_in      packet from flow control; MSB is the valid flag
//   resend         previous cycle's valid packet was not captured
//   self_leaf      this leaf's address (quasi-static)
//   pkt_out        head packet toward the switch; all-zero when empty
//   pkt_out_accept switch consumed pkt_out this cycle
//   level          current FIFO occupancy
//   sent_cnt       packets accepted by the switch (wraps)
//   reject_cnt     packets not captured (saturates)
//   self_addr_cnt  captured packets addressed to self_leaf (saturates)
module leaf_egress_buffer #(
    parameter int PACKET_BITS     = 97,
    parameter int NUM_LEAF_BITS   = 6,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PACKET_BITS-1:0]     stream_in,
    output logic                       resend,
    input  logic [NUM_LEAF_BITS-1:0]   self_leaf,
    output logic [PACKET_BITS-1:0]     pkt_out,
    input  logic                       pkt_out_accept,
    output logic [FIFO_DEPTH_BITS:0]   level,
    output logic [31:0]                sent_cnt,
    output logic [15:0]                reject_cnt,
    output logic [15:0]                self_addr_cnt
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   FULL_CNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};

    logic [PACKET_BITS-1:0]     mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;

    logic in_valid;
    logic full;
    logic empty;
    logic wr_en;
    logic rej_en;
    logic pop_en;
    logic dest_is_self;

    assign in_valid     = stream_in[PACKET_BITS-1];
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    // Full test uses the count at the start of the cycle: a same-cycle pop
    // does not free a slot for the incoming packet.
    assign wr_en        = in_valid && !full;
    assign rej_en       = in_valid && full;
    assign pop_en       = pkt_out_accept && !empty;
    assign dest_is_self = (stream_in[PACKET_BITS-2 -: NUM_LEAF_BITS] == self_leaf);

    // Storage carries no reset; contents are only observed when count > 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= stream_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            resend        <= 1'b0;
            sent_cnt      <= '0;
            reject_cnt    <= '0;
            self_addr_cnt <= '0;
        end else begin
            resend <= rej_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                sent_cnt <= sent_cnt + 32'd1;
            end
            case ({wr_en, pop_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (rej_en && reject_cnt != 16'hFFFF) begin
                reject_cnt <= reject_cnt + 16'd1;
            end
            if (wr_en && dest_is_self && self_addr_cnt != 16'hFFFF) begin
                self_addr_cnt <= self_addr_cnt + 16'd1;
            end
        end
    end

    // Outputs depend only on registers, so async reset clears them at once.
    assign pkt_out = empty ? '0 : mem[rd_ptr];
    assign level   = count;

endmodule

// File: tb/tb_leaf_egress_buffer.sv
module tb_leaf_egress_buffer;

    localparam int PB    = 97;
    localparam int LB    = 6;
    localparam int DB    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PB-1:0] stream_in = '0;
    logic          resend;
    logic [LB-1:0] self_leaf = 6'd5;
    logic [PB-1:0] pkt_out;
    logic          pkt_out_accept = 1'b0;
    logic [DB:0]   level;
    logic [31:0]   sent_cnt;
    logic [15:0]   reject_cnt;
    logic [15:0]   self_addr_cnt;

    leaf_egress_buffer #(.PACKET_BITS(PB), .NUM_LEAF_BITS(LB), .FIFO_DEPTH_BITS(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .stream_in      (stream_in),
        .resend         (resend),
        .self_leaf      (self_leaf),
        .pkt_out        (pkt_out),
        .pkt_out_accept (pkt_out_accept),
        .level          (level),
        .sent_cnt       (sent_cnt),
        .reject_cnt     (reject_cnt),
        .self_addr_cnt  (self_addr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard: packets expected on pkt_out, in order.
    logic [PB-1:0] exp_q[$];
    logic [31:0]   m_sent;
    logic [15:0]   m_rej;
    logic [15:0]   m_self;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PB-1:0] mkpkt(input logic [LB-1:0] dest, input logic [31:0] payload);
        logic [PB-1:0] p;
        p = '0;
        p[PB-1] = 1'b1;
        p[PB-2 -: LB] = dest;
        p[31:0] = payload;
        return p;
    endfunction

    // Drive one cycle of stimulus, update the model, check after the edge.
    task automatic step(input logic [PB-1:0] pkt, input logic acc);
        int   pre;
        logic wr, rej, pop;
        logic [PB-1:0] exp_head;
        stream_in      = pkt;
        pkt_out_accept = acc;
        pre = exp_q.size();
        wr  = pkt[PB-1] && (pre < DEPTH);
        rej = pkt[PB-1] && (pre == DEPTH);
        pop = acc && (pre > 0);
        if (pop) begin
            chk("head", {31'd0, pkt_out}, {31'd0, exp_q[0]});
            void'(exp_q.pop_front());
            m_sent = m_sent + 32'd1;
        end
        if (wr) begin
            exp_q.push_back(pkt);
            if (pkt[PB-2 -: LB] == self_leaf && m_self != 16'hFFFF) m_self = m_self + 16'd1;
        end
        if (rej && m_rej != 16'hFFFF) m_rej = m_rej + 16'd1;
        @(posedge clk);
        #1;
        stream_in      = '0;
        pkt_out_accept = 1'b0;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("level", 128'(level), 128'(exp_q.size()));
        chk("resend", 128'(resend), 128'(rej));
        chk("sent_cnt", 128'(sent_cnt), 128'(m_sent));
        chk("reject_cnt", 128'(reject_cnt), 128'(m_rej));
        chk("self_addr_cnt", 128'(self_addr_cnt), 128'(m_self));
        chk("pkt_out", {31'd0, pkt_out}, {31'd0, exp_head});
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_sent = '0;
        m_rej  = '0;
        m_self = '0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stream_in      = '0;
        pkt_out_accept = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_pkt_out", {31'd0, pkt_out}, 128'd0);
        chk("rst_resend", 128'(resend), 128'd0);
        chk("rst_sent", 128'(sent_cnt), 128'd0);
        chk("rst_reject", 128'(reject_cnt), 128'd0);
        chk("rst_self", 128'(self_addr_cnt), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PB-1:0] junk;
        model_clear();

        // Single packet, then accept it.
        do_reset();
        step(mkpkt(6'd3, 32'hA5), 1'b0);
        chk("single_level", 128'(level), 128'd1);
        step('0, 1'b1);
        chk("single_sent", 128'(sent_cnt), 128'd1);

        // Overflow: six packets into depth 4, then drain in order.
        do_reset();
        for (int i = 0; i < 6; i++) step(mkpkt(6'd1, 32'h100 + i), 1'b0);
        chk("ovf_reject", 128'(reject_cnt), 128'd2);
        for (int i = 0; i < 4; i++) step('0, 1'b1);

        // Full with accept and write in the same cycle: write is rejected.
        do_reset();
        for (int i = 0; i < 4; i++) step(mkpkt(6'd2, 32'h200 + i), 1'b0);
        step(mkpkt(6'd2, 32'h2FF), 1'b1);
        chk("full_pop_level", 128'(level), 128'd3);
        chk("full_pop_resend", 128'(resend), 128'd1);
        for (int i = 0; i < 3; i++) step('0, 1'b1);

        // Steady state at level 2 across pointer wrap.
        do_reset();
        step(mkpkt(6'd7, 32'h300), 1'b0);
        step(mkpkt(6'd7, 32'h301), 1'b0);
        for (int i = 0; i < 10; i++) step(mkpkt(6'd7, 32'h310 + i), 1'b1);
        chk("steady_level", 128'(level), 128'd2);
        chk("steady_sent", 128'(sent_cnt), 128'd10);
        step('0, 1'b1);
        step('0, 1'b1);

        // Invalid packets and accepts while empty change nothing.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            junk = {$urandom, $urandom, $urandom, $urandom};
            junk[PB-1] = 1'b0;
            step(junk, 1'(i % 2));
        end
        chk("invalid_sent", 128'(sent_cnt), 128'd0);
        chk("invalid_level", 128'(level), 128'd0);

        // Self-addressed packets are counted and still delivered.
        do_reset();
        step(mkpkt(6'd5, 32'h400), 1'b0);
        step(mkpkt(6'd4, 32'h401), 1'b0);
        step(mkpkt(6'd5, 32'h402), 1'b0);
        step(mkpkt(6'd5, 32'h403), 1'b0);
        chk("self_cnt", 128'(self_addr_cnt), 128'd3);
        for (int i = 0; i < 4; i++) step('0, 1'b1);
        chk("self_sent", 128'(sent_cnt), 128'd4);

        // Async reset mid-cycle with three queued packets.
        for (int i = 0; i < 3; i++) step(mkpkt(6'd9, 32'h500 + i), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_level", 128'(level), 128'd0);
        chk("async_pkt_out", {31'd0, pkt_out}, 128'd0);
        chk("async_self", 128'(self_addr_cnt), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step('0, 1'b0);
        step('0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_egress_buffer.md
# leaf_egress_buffer

Egress stage between a leaf's stream flow-control block and its butterfly-fat-tree switch port. It captures packets presented on the flow-control block's `stream_out` into a small first-word-fall-through FIFO and presents them to the switch until the switch accepts them. When a packet cannot be captured, it raises `resend` toward the flow-control block so the packet is re-issued. Occupancy and statistics outputs support the done-mode/counter readout path.

## Interface
Parameters:
- `PACKET_BITS`, 97: packet width; bit `PACKET_BITS-1` is the valid flag.
- `NUM_LEAF_BITS`, 6: destination-leaf field width, bits `[PACKET_BITS-2 -: NUM_LEAF_BITS]`.
- `FIFO_DEPTH_BITS`, 2: log2 of FIFO depth (default depth 4); legal range 1..6.

Ports:
- `clk` in 1: clock; every register in the block is clocked by it.
- `reset` in 1: asynchronous, active-high.
- `stream_in` in PACKET_BITS: packet from the flow-control block's `stream_out`.
- `resend` out 1: the valid packet on `stream_in` in the previous cycle was not captured.
- `self_leaf` in NUM_LEAF_BITS: this leaf's address, quasi-static.
- `pkt_out` out PACKET_BITS: head packet to the switch; all-zero when empty.
- `pkt_out_accept` in 1: the switch consumed `pkt_out` this cycle.
- `level` out FIFO_DEPTH_BITS+1: current occupancy.
- `sent_cnt` out 32: packets accepted by the switch; wraps.
- `reject_cnt` out 16: packets not captured; saturates at 16'hFFFF.
- `self_addr_cnt` out 16: captured packets whose destination leaf equals `self_leaf`; saturates.

## Operation
- Storage is a register array of depth `2**FIFO_DEPTH_BITS`, with wr_ptr/rd_ptr of FIFO_DEPTH_BITS bits (natural wrap) and count of FIFO_DEPTH_BITS+1 bits.
- Write condition: `stream_in[PACKET_BITS-1]` && count < depth.
  - The full test uses the count registered at the start of the cycle. A pop in the same cycle does not make room; there is no write-through when full.
- Packets with the valid bit = 0 are ignored. They do not touch any state or counter.
- Reject condition: valid && count == depth. On reject:
  - `resend` = 1 on the next cycle.
  - `reject_cnt` increments.
- Pop condition: `pkt_out_accept` && count > 0. On pop:
  - rd_ptr advances.
  - `sent_cnt` increments.
  - `pkt_out_accept` while empty is ignored.
- Simultaneous write and pop with 0 < count < depth: count is unchanged and both pointers advance.
- `pkt_out` = mem[rd_ptr] when count > 0, else all zeros. The stored valid bit is always 1.
- `self_addr_cnt` increments on a write whose destination field equals `self_leaf`. The packet is still queued normally; this is diagnostic only.
- `level` = count.
- No state machine beyond the FIFO. The block is a pure buffering and handshake stage.

## Timing
- Reset (asynchronous assert; deassert sampled at `clk`): count, pointers, `resend`, all counters = 0; `pkt_out` = 0.
  - FIFO contents are don't-care.
  - Reset mid-stream discards queued packets. No `resend` is generated for them.
- Latency `stream_in` -> `pkt_out`:
  - 1 cycle when empty (first-word fall-through after the write edge).
  - Otherwise, behind earlier entries.
- `resend` is registered and high for exactly one cycle per rejected packet. It is high on consecutive cycles for consecutive rejects.
- Counters update on the same edge as the triggering write, pop, or reject.
- `level` and `pkt_out` are registered or derived only from registers. There is no combinational path from `stream_in` or `pkt_out_accept` to any output.
- Wrap: pointers wrap modulo depth. `sent_cnt` wraps 32'hFFFFFFFF -> 0. `reject_cnt` and `self_addr_cnt` hold at 16'hFFFF.

## Test plan
- Reset, then one valid packet (payload 0xA5, dest leaf 3, `self_leaf` = 5) with `pkt_out_accept` held 0 -> next cycle: `pkt_out` equals the packet, `level` = 1, `resend` = 0. Then accept one cycle -> `level` = 0, `pkt_out` = 0, `sent_cnt` = 1.
- Depth 4, accept held 0, 6 consecutive valid packets P0..P5 -> `level` = 4; `resend` high on the two cycles after P4 and P5; `reject_cnt` = 2. Then 4 accepts -> P0..P3 in order.
- FIFO full plus accept plus a valid write in the same cycle -> write rejected, `resend` = 1 next cycle, `level` = 3.
- `level` = 2 with a write and an accept every cycle for 10 cycles -> `level` stays 2; order preserved across pointer wrap; `sent_cnt` = 10.
- Invalid packets (MSB = 0, other bits random) for 20 cycles -> no state change; accept while empty leaves `sent_cnt` = 0.
- Dest leaf = `self_leaf` = 5 on three packets -> `self_addr_cnt` = 3, all three delivered. Async reset asserted mid-cycle with `level` = 3 -> outputs zero immediately, before the next edge.
